// File: rtl/dino_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dino_pkg : shared types, register map and BCD helper for Dino Run
// Rev 1.0
// ------------------------------------------------------------------
package dino_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } game_state_t;

   localparam logic [2:0] REG_CTRL    = 3'd0;
   localparam logic [2:0] REG_STATUS  = 3'd1;
   localparam logic [2:0] REG_SCORE   = 3'd2;
   localparam logic [2:0] REG_HISCORE = 3'd3;

   localparam int CTRL_START  = 0;
   localparam int CTRL_STOP   = 1;
   localparam int CTRL_CLR_HI = 2;
   localparam int CTRL_BUMP   = 3;

   localparam logic [11:0] SCORE_MAX_BCD = 12'h999;

   // Adds a small increment (0..3) to one BCD digit; returns {carry, digit}.
   function automatic logic [4:0] bcd_digit_add(input logic [3:0] digit,
                                                input logic [1:0] inc);
      logic [4:0] s;
      s = {1'b0, digit} + {3'b000, inc};
      if (s > 5'd9) begin
         return {1'b1, s[3:0] - 4'd10};
      end
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dino_score_keeper_if.sv
`default_nettype none
// ------------------------------------------------------------------
// dino_score_keeper_if : chipselect/write/read register bus
// Rev 1.0
// ------------------------------------------------------------------
interface dino_score_keeper_if;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [2:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output chipselect, write, read, address, writedata,
      input  readdata
   );

   modport slave (
      input  chipselect, write, read, address, writedata,
      output readdata
   );
endinterface
`default_nettype wire

// File: rtl/bcd_add3_sat.sv
`default_nettype none
// ------------------------------------------------------------------
// bcd_add3_sat : 3-digit BCD + 2-bit increment, saturating at 999
// Rev 1.0
// ------------------------------------------------------------------
module bcd_add3_sat
   import dino_pkg::*;
(
   input  logic [11:0] value,
   input  logic [1:0]  inc,
   output logic [11:0] sum
);

   logic [4:0] w_ones;
   logic [4:0] w_tens;
   logic [4:0] w_hund;

   always_comb begin
      w_ones = bcd_digit_add(value[3:0], inc);
      w_tens = bcd_digit_add(value[7:4], {1'b0, w_ones[4]});
      w_hund = bcd_digit_add(value[11:8], {1'b0, w_tens[4]});
      // A carry out of the hundreds digit means the true sum passed 999.
      if (w_hund[4]) begin
         sum = SCORE_MAX_BCD;
      end else begin
         sum = {w_hund[3:0], w_tens[3:0], w_ones[3:0]};
      end
   end

endmodule
`default_nettype wire

// File: rtl/dino_score_keeper.sv
`default_nettype none
// ------------------------------------------------------------------
// dino_score_keeper : game FSM, BCD score/high score, frame shadows
// Rev 1.0
// ------------------------------------------------------------------
module dino_score_keeper
   import dino_pkg::*;
#(
   parameter int TICK_CYCLES = 5_000_000
)
(
   input  logic                      clk,
   input  logic                      reset_n,
   dino_score_keeper_if.slave        bus,
   input  logic                      frame_start,
   output logic [11:0]               score_bcd,
   output logic [11:0]               hiscore_bcd,
   output logic [1:0]                game_state
);

   localparam int               CNT_W    = $clog2(TICK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_OVER = ST_OVER;

   logic [1:0]       r_state;
   logic [11:0]      r_score;
   logic [11:0]      r_hiscore;
   logic [CNT_W-1:0] r_cnt;
   logic [11:0]      r_score_sh;
   logic [11:0]      r_hiscore_sh;
   logic [31:0]      r_readdata;

   logic        w_ctrl_wr;
   logic        w_start;
   logic        w_stop;
   logic        w_clr_hi;
   logic        w_bump_run;
   logic        w_tick;
   logic        w_enter_over;
   logic [1:0]  w_inc;
   logic [11:0] w_score_next;
   logic        w_unused_wdata;

   assign w_ctrl_wr    = bus.chipselect && bus.write && (bus.address == REG_CTRL);
   assign w_start      = w_ctrl_wr && bus.writedata[CTRL_START];
   assign w_stop       = w_ctrl_wr && bus.writedata[CTRL_STOP];
   assign w_clr_hi     = w_ctrl_wr && bus.writedata[CTRL_CLR_HI];
   assign w_bump_run   = w_ctrl_wr && bus.writedata[CTRL_BUMP] && (r_state == S_RUN);
   assign w_tick       = (r_state == S_RUN) && (r_cnt == CNT_LAST);
   assign w_enter_over = (r_state == S_RUN) && w_stop && !w_start;
   assign w_inc        = {1'b0, w_tick} + {1'b0, w_bump_run};
   assign w_unused_wdata = &{1'b0, bus.writedata[31:4]};

   bcd_add3_sat u_add (
      .value (r_score),
      .inc   (w_inc),
      .sum   (w_score_next)
   );

   // START takes priority over everything, including a simultaneous STOP.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_score <= 12'h000;
         r_cnt   <= '0;
      end else if (w_start) begin
         r_state <= S_RUN;
         r_score <= 12'h000;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_score <= 12'h000;
            end
            S_RUN: begin
               if (w_stop) begin
                  r_state <= S_OVER;
               end else begin
                  r_score <= w_score_next;
                  r_cnt   <= w_tick ? '0 : r_cnt + CNT_ONE;
               end
            end
            S_OVER: begin
               r_state <= S_OVER;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hiscore <= 12'h000;
      end else if (w_clr_hi) begin
         r_hiscore <= 12'h000;
      end else if (w_enter_over && (r_score > r_hiscore)) begin
         r_hiscore <= r_score;
      end
   end

   // Shadows only move on the frame boundary so digits never tear mid-frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_score_sh   <= 12'h000;
         r_hiscore_sh <= 12'h000;
      end else if (frame_start) begin
         r_score_sh   <= r_score;
         r_hiscore_sh <= r_hiscore;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= 32'd0;
      end else if (bus.chipselect && bus.read) begin
         case (bus.address)
            REG_STATUS:  r_readdata <= {30'd0, r_state};
            REG_SCORE:   r_readdata <= {20'd0, r_score};
            REG_HISCORE: r_readdata <= {20'd0, r_hiscore};
            default:     r_readdata <= 32'd0;
         endcase
      end
   end

   assign bus.readdata = r_readdata;
   assign score_bcd    = r_score_sh;
   assign hiscore_bcd  = r_hiscore_sh;
   assign game_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dino_score_keeper.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_dino_score_keeper : directed self-checking bench, TICK_CYCLES=4
// Rev 1.0
// ------------------------------------------------------------------
module tb_dino_score_keeper;
   import dino_pkg::*;

   localparam int          TICKS   = 4;
   localparam logic [31:0] W_START = 32'h1;
   localparam logic [31:0] W_STOP  = 32'h2;
   localparam logic [31:0] W_CLR   = 32'h4;
   localparam logic [31:0] W_BUMP  = 32'h8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        frame_start = 1'b0;
   logic [11:0] score_bcd;
   logic [11:0] hiscore_bcd;
   logic [1:0]  game_state;
   logic [31:0] d;
   int          total = 0;
   int          bad = 0;

   dino_score_keeper_if bus ();

   dino_score_keeper #(.TICK_CYCLES(TICKS)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .frame_start (frame_start),
      .score_bcd   (score_bcd),
      .hiscore_bcd (hiscore_bcd),
      .game_state  (game_state)
   );

   always #5 clk = ~clk;

   // Every bus task starts and ends 1 ns after a rising edge.
   task automatic bus_write(input logic [31:0] wd);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = REG_CTRL; bus.writedata = wd;
      @(posedge clk); #1;
      bus.chipselect = 1'b0; bus.write = 1'b0; bus.writedata = 32'd0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] rd);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
      @(posedge clk); #1;
      bus.chipselect = 1'b0; bus.read = 1'b0;
      rd = bus.readdata;
   endtask

   task automatic bump_for(input int n);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = REG_CTRL; bus.writedata = W_BUMP;
      repeat (n) @(posedge clk);
      #1;
      bus.chipselect = 1'b0; bus.write = 1'b0; bus.writedata = 32'd0;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      total++; if (game_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%h want=0", game_state); end
      total++; if (score_bcd !== 12'h000) begin bad++; $display("FAIL rst_score_bcd got=%h want=000", score_bcd); end
      total++; if (hiscore_bcd !== 12'h000) begin bad++; $display("FAIL rst_hiscore_bcd got=%h want=000", hiscore_bcd); end
      total++; if (bus.readdata !== 32'd0) begin bad++; $display("FAIL rst_readdata got=%h want=0", bus.readdata); end
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      bus_write(W_STOP);
      total++; if (game_state !== 2'd0) begin bad++; $display("FAIL idle_stop got=%h want=0", game_state); end
      bus_read(REG_SCORE, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL idle_score got=%h want=0", d); end
      bus_write(W_START | W_STOP);
      total++; if (game_state !== 2'd1) begin bad++; $display("FAIL start_stop_wins got=%h want=1", game_state); end
      bus_read(REG_STATUS, d);
      total++; if (d !== 32'd1) begin bad++; $display("FAIL status_run got=%h want=1", d); end
      bus_read(3'd5, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped_read got=%h want=0", d); end
   endtask

   task automatic test_run_count();
      bus_write(W_START);
      repeat (40) @(posedge clk);
      #1;
      bus_read(REG_SCORE, d);
      total++; if (d !== 32'h010) begin bad++; $display("FAIL run_score got=%h want=010", d); end
      total++; if (score_bcd !== 12'h000) begin bad++; $display("FAIL shadow_hold got=%h want=000", score_bcd); end
      bus_write(W_STOP);
      repeat (3) @(posedge clk);
      #1;
      frame_start = 1'b1;
      @(negedge clk);
      total++; if (score_bcd !== 12'h000) begin bad++; $display("FAIL shadow_pre got=%h want=000", score_bcd); end
      @(posedge clk); #1;
      frame_start = 1'b0;
      total++; if (score_bcd !== 12'h010) begin bad++; $display("FAIL shadow_score got=%h want=010", score_bcd); end
      total++; if (hiscore_bcd !== 12'h010) begin bad++; $display("FAIL shadow_hiscore got=%h want=010", hiscore_bcd); end
   endtask

   task automatic test_bcd_carry();
      bus_write(W_START);
      bump_for(159);
      @(posedge clk); #1;
      bus_read(REG_SCORE, d);
      total++; if (d !== 32'h199) begin bad++; $display("FAIL score_199 got=%h want=199", d); end
      repeat (3) @(posedge clk);
      #1;
      bus_read(REG_SCORE, d);
      total++; if (d !== 32'h200) begin bad++; $display("FAIL carry_200 got=%h want=200", d); end
   endtask

   task automatic test_saturate();
      bus_write(W_START);
      bump_for(798);
      repeat (2) @(posedge clk);
      #1;
      bus_read(REG_SCORE, d);
      total++; if (d !== 32'h998) begin bad++; $display("FAIL score_998 got=%h want=998", d); end
      repeat (2) @(posedge clk);
      #1;
      bus_write(W_BUMP);
      bus_read(REG_SCORE, d);
      total++; if (d !== 32'h999) begin bad++; $display("FAIL sat_999 got=%h want=999", d); end
      repeat (3) @(posedge clk);
      #1;
      bus_read(REG_SCORE, d);
      total++; if (d !== 32'h999) begin bad++; $display("FAIL sat_hold got=%h want=999", d); end
   endtask

   task automatic test_hiscore();
      bus_write(W_CLR);
      bus_write(W_START);
      bump_for(34);
      bus_write(W_STOP);
      total++; if (game_state !== 2'd2) begin bad++; $display("FAIL over_state got=%h want=2", game_state); end
      bus_read(REG_HISCORE, d);
      total++; if (d !== 32'h042) begin bad++; $display("FAIL hiscore_042 got=%h want=042", d); end
      bus_write(W_START);
      bump_for(24);
      bus_write(W_STOP);
      repeat (8) @(posedge clk);
      #1;
      bus_read(REG_SCORE, d);
      total++; if (d !== 32'h030) begin bad++; $display("FAIL over_frozen got=%h want=030", d); end
      bus_read(REG_HISCORE, d);
      total++; if (d !== 32'h042) begin bad++; $display("FAIL hiscore_kept got=%h want=042", d); end
   endtask

   task automatic test_clr_hi();
      bus_write(W_START);
      bump_for(40);
      bus_write(W_STOP | W_CLR);
      total++; if (game_state !== 2'd2) begin bad++; $display("FAIL clr_over_state got=%h want=2", game_state); end
      bus_read(REG_HISCORE, d);
      total++; if (d !== 32'h000) begin bad++; $display("FAIL clr_wins got=%h want=000", d); end
      bus_read(REG_SCORE, d);
      total++; if (d !== 32'h050) begin bad++; $display("FAIL clr_score got=%h want=050", d); end
   endtask

   task automatic test_async_reset();
      bus_write(W_START);
      bump_for(99);
      frame_start = 1'b1;
      bus_read(REG_SCORE, d);
      frame_start = 1'b0;
      total++; if (d !== 32'h123) begin bad++; $display("FAIL pre_rst_score got=%h want=123", d); end
      total++; if (score_bcd !== 12'h123) begin bad++; $display("FAIL pre_rst_shadow got=%h want=123", score_bcd); end
      #2 reset_n = 1'b0;
      #1;
      total++; if (game_state !== 2'd0) begin bad++; $display("FAIL arst_state got=%h want=0", game_state); end
      total++; if (score_bcd !== 12'h000) begin bad++; $display("FAIL arst_score_bcd got=%h want=000", score_bcd); end
      total++; if (bus.readdata !== 32'd0) begin bad++; $display("FAIL arst_readdata got=%h want=0", bus.readdata); end
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      bus_read(REG_STATUS, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL post_rst_state got=%h want=0", d); end
      repeat (6) @(posedge clk);
      #1;
      bus_read(REG_SCORE, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL post_rst_score got=%h want=0", d); end
   endtask

   initial begin
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
      bus.read       = 1'b0;
      bus.address    = 3'd0;
      bus.writedata  = 32'd0;
      test_reset();
      test_run_count();
      test_bcd_carry();
      test_saturate();
      test_hiscore();
      test_clr_hi();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
